// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer sharing one multi-cycle signed divider
// among NUM_REQ requesters. Grants one request at a time from IDLE, starts the
// divider with latched operands, waits for fin (bounded by TIMEOUT), and
// returns the quotient with a one-cycle one-hot valid pulse. A zero divisor is
// answered locally with a saturated quotient and the divider is never started.
module div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 63
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ*DW-1:0] i_a,
  input  logic [NUM_REQ*DW-1:0] i_b,
  output logic [NUM_REQ-1:0]    o_gnt,
  output logic [NUM_REQ-1:0]    o_rsp_vld,
  output logic [DW-1:0]         o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_busy,
  output logic                  o_div_en,
  output logic [DW-1:0]         o_div_a,
  output logic [DW-1:0]         o_div_b,
  input  logic                  i_div_fin,
  input  logic [DW-1:0]         i_div_result
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_sel;
  logic [7:0]            r_cnt;
  logic signed [DW-1:0]  r_a;
  logic signed [DW-1:0]  r_b;

  logic                  w_found;
  logic [IW-1:0]         w_sel;
  logic signed [DW-1:0]  w_a;
  logic signed [DW-1:0]  w_b;

  // Quotient returned for a zero divisor: saturate towards the dividend's sign.
  function automatic logic [DW-1:0] div0_sat(input logic signed [DW-1:0] a);
    if (a < 0) div0_sat = {1'b1, {(DW-1){1'b0}}};
    else       div0_sat = {1'b0, {(DW-1){1'b1}}};
  endfunction

  // Round-robin search starting just after the last winner; ptr itself is checked last.
  always_comb begin : p_search
    logic [IW-1:0] k;
    k       = '0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = IW'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && i_req[k]) begin
        w_found = 1'b1;
        w_sel   = k;
      end
    end
  end

  assign w_a = i_a[w_sel*DW +: DW];
  assign w_b = i_b[w_sel*DW +: DW];

  // Grant is combinational and only offered while idle.
  assign o_gnt   = (r_state == S_IDLE && w_found) ? (NUM_REQ'(1) << w_sel) : '0;
  assign o_busy  = (r_state != S_IDLE);
  assign o_div_a = r_a;
  assign o_div_b = r_b;

  // Sequencer FSM with registered divider start and response outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= IW'(NUM_REQ - 1);
      r_sel      <= '0;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      o_rsp_vld  <= '0;
      o_rsp_data <= '0;
      o_rsp_err  <= 1'b0;
      o_div_en   <= 1'b0;
    end else begin
      o_div_en  <= 1'b0;
      o_rsp_vld <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sel <= w_sel;
            r_ptr <= w_sel;
            r_a   <= w_a;
            r_b   <= w_b;
            if (w_b != 0) begin
              r_state  <= S_ISSUE;
              o_div_en <= 1'b1;
            end else begin
              // Zero divisor: answer next cycle without touching the divider.
              r_state    <= S_RESP;
              o_rsp_vld  <= NUM_REQ'(1) << w_sel;
              o_rsp_data <= div0_sat(w_a);
              o_rsp_err  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_div_fin) begin
            r_state    <= S_RESP;
            o_rsp_vld  <= NUM_REQ'(1) << r_sel;
            o_rsp_data <= i_div_result;
            o_rsp_err  <= 1'b0;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            // This cycle is the TIMEOUT-th without fin: abort the request.
            r_state    <= S_RESP;
            o_rsp_vld  <= NUM_REQ'(1) << r_sel;
            o_rsp_data <= '0;
            o_rsp_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
